// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters through an accept/execute/respond FSM.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every contention (default build: round-robin).

module alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            ctrl_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  eq_o
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic           shift_oob;
    logic [SHW-1:0] shamt;

    // The shift amount is the whole op2 value, so anything past the width flushes to zero.
    assign shift_oob = |(op2_i >> SHW);
    assign shamt     = op2_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            3'b000: result_o = op1_i + op2_i;
            3'b001: result_o = op1_i - op2_i;
            3'b010: result_o = op1_i & op2_i;
            3'b011: result_o = op1_i | op2_i;
            3'b100: result_o = {{(DATA_WIDTH-1){1'b0}}, (op2_i < op1_i)};
            3'b101: result_o = op1_i ^ op2_i;
            3'b110: result_o = shift_oob ? '0 : (op1_i << shamt);
            default: result_o = shift_oob ? '0 : (op1_i >> shamt);
        endcase
    end

    assign eq_o = (result_o == '0);
endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*3-1:0]          req_ctrl,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_eq,
    output logic                          busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic                  id;
        logic [2:0]            ctrl;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] op1;
    } op_t;

    logic [1:0]                         state_q, state_d;
    op_t                                op_q, op_d;
    logic                               rsp_valid_q;
    logic                               rsp_id_q;
    logic [DATA_WIDTH-1:0]              rsp_result_q;
    logic                               rsp_eq_q;
    logic                               busy_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                               last_grant_q;
`endif

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op1_lane;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op2_lane;
    logic [NUM_REQ-1:0][2:0]            ctrl_lane;
    logic                               gnt_vld;
    logic                               gnt_id;
    logic [DATA_WIDTH-1:0]              alu_res;
    logic                               alu_eq;

    assign op1_lane  = req_op1;
    assign op2_lane  = req_op2;
    assign ctrl_lane = req_ctrl;

    always_comb begin
        gnt_vld = (state_q == S_IDLE) && !rst && (|req_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_id = !req_valid[0];
`else
        // Contention goes to whoever did not win last time; a lone request always wins.
        gnt_id = (&req_valid) ? !last_grant_q : req_valid[1];
`endif
        req_ready = '0;
        if (gnt_vld)
            req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        op_d.id   = gnt_id;
        op_d.ctrl = ctrl_lane[gnt_id];
        op_d.op2  = op2_lane[gnt_id];
        op_d.op1  = op1_lane[gnt_id];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_vld)   state_d = S_EXEC;
            S_EXEC:                 state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .ctrl_i   (op_q.ctrl),
        .op1_i    (op_q.op1),
        .op2_i    (op_q.op2),
        .result_o (alu_res),
        .eq_o     (alu_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_eq_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            if (gnt_vld) begin
                op_q <= op_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant_q <= gnt_id;
`endif
            end
            // Response fields only change on EXEC; they keep their last value after the handshake.
            if (state_q == S_EXEC) begin
                rsp_result_q <= alu_res;
                rsp_eq_q     <= alu_eq;
                rsp_id_q     <= op_q.id;
                rsp_valid_q  <= 1'b1;
            end else if (state_q == S_RESP && rsp_ready) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_eq     = rsp_eq_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, mid-op reset, then random traffic vs a transaction model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1, req_op2;
    logic [5:0]  req_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_eq, busy;
    logic [31:0] rsp_result;

    int   checks = 0;
    int   errors = 0;
    logic m_last = 1'b1;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a0, b0;
        logic [2:0]  c0;
        logic [31:0] a1, b1;
        logic [2:0]  c1;
        int          bp;
        logic [1:0]  hold;
        logic        id;
        logic [31:0] res;
        logic        eq;
    } vec_t;

    vec_t tbl[9];

    alu_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] alu_ref(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (b < a) ? 32'd1 : 32'd0;
            3'd5: return a ^ b;
            3'd6: return (b >= 32) ? 32'd0 : a << b;
            default: return (b >= 32) ? 32'd0 : a >> b;
        endcase
    endfunction

    function automatic logic pick(logic [1:0] m, logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return m[0] ? 1'b0 : 1'b1;
`else
        if (m == 2'b11) return !last;
        return m[1];
`endif
    endfunction

    function automatic logic [1:0] oh(logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one transaction starting in IDLE and walks it through grant, execute, backpressure and handshake.
    task automatic txn(input vec_t v, input string nm);
        req_valid = v.m;
        req_op1   = {v.a1, v.a0};
        req_op2   = {v.b1, v.b0};
        req_ctrl  = {v.c1, v.c0};
        rsp_ready = 1'b0;
        #1;
        chk({nm, " grant"}, 32'(req_ready), 32'(oh(v.id)));
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
        @(posedge clk); #2;
        m_last    = v.id;
        req_valid = v.hold;
        #1;
        chk({nm, " exec busy"}, 32'(busy), 32'd1);
        chk({nm, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, " exec ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        for (int k = 0; k <= v.bp; k++) begin
            rsp_ready = (k == v.bp);
            #1;
            chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, " rsp_id"}, 32'(rsp_id), 32'(v.id));
            chk({nm, " rsp_result"}, rsp_result, v.res);
            chk({nm, " rsp_eq"}, 32'(rsp_eq), 32'(v.eq));
            chk({nm, " resp ready"}, 32'(req_ready), 32'd0);
            chk({nm, " resp busy"}, 32'(busy), 32'd1);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b0;
        #1;
        chk({nm, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, " post busy"}, 32'(busy), 32'd0);
        chk({nm, " post result kept"}, rsp_result, v.res);
        chk({nm, " post id kept"}, 32'(rsp_id), 32'(v.id));
        chk({nm, " reaccept"}, 32'(req_ready), (v.hold == 2'b00) ? 32'd0 : 32'(oh(pick(v.hold, m_last))));
        req_valid = 2'b00;
    endtask

    initial begin
        vec_t rv;
        logic [1:0] gm;

        //       m      a0            b0          c0    a1          b1          c1    bp hold   id    res            eq
        tbl[0] = '{2'b11, 32'd9,        32'd9,      3'd1, 32'hF0,     32'h0F,     3'd3, 0, 2'b00, 1'b0, 32'd0,         1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
        tbl[1] = '{2'b11, 32'd9,        32'd9,      3'd1, 32'hF0,     32'h0F,     3'd3, 0, 2'b00, 1'b0, 32'd0,         1'b1};
`else
        tbl[1] = '{2'b11, 32'd9,        32'd9,      3'd1, 32'hF0,     32'h0F,     3'd3, 0, 2'b00, 1'b1, 32'hFF,        1'b0};
`endif
        tbl[2] = '{2'b11, 32'd9,        32'd9,      3'd1, 32'hF0,     32'h0F,     3'd3, 0, 2'b00, 1'b0, 32'd0,         1'b1};
        tbl[3] = '{2'b01, 32'd5,        32'd7,      3'd0, 32'd0,      32'd0,      3'd0, 0, 2'b00, 1'b0, 32'd12,        1'b0};
        tbl[4] = '{2'b10, 32'd0,        32'd0,      3'd0, 32'd1,      32'd31,     3'd6, 1, 2'b00, 1'b1, 32'h80000000,  1'b0};
        tbl[5] = '{2'b01, 32'hFFFFFFFF, 32'd32,     3'd7, 32'd0,      32'd0,      3'd0, 0, 2'b00, 1'b0, 32'd0,         1'b1};
        tbl[6] = '{2'b10, 32'd0,        32'd0,      3'd0, 32'd3,      32'd2,      3'd4, 0, 2'b00, 1'b1, 32'd1,         1'b0};
        tbl[7] = '{2'b01, 32'd2,        32'd3,      3'd4, 32'd0,      32'd0,      3'd0, 0, 2'b00, 1'b0, 32'd0,         1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
        tbl[8] = '{2'b11, 32'h1000,     32'h234,    3'd0, 32'h1234,   32'd0,      3'd5, 5, 2'b11, 1'b0, 32'h1234,      1'b0};
`else
        tbl[8] = '{2'b11, 32'h1000,     32'h234,    3'd0, 32'h1234,   32'd0,      3'd5, 5, 2'b11, 1'b1, 32'h1234,      1'b0};
`endif

        rst = 1'b1; req_valid = 2'b11; req_op1 = '0; req_op2 = '0; req_ctrl = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset rsp_result", rsp_result, 32'd0);
            chk("reset rsp_eq", 32'(rsp_eq), 32'd0);
            chk("reset rsp_id", 32'(rsp_id), 32'd0);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset ready", 32'(req_ready), 32'd0);
        end
        rst = 1'b0; req_valid = 2'b00;
        @(posedge clk); #2;
        chk("after reset busy", 32'(busy), 32'd0);
        chk("after reset rsp_valid", 32'(rsp_valid), 32'd0);
        m_last = 1'b1;

        for (int i = 0; i < 9; i++)
            txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while executing: the op must vanish without a response.
        req_valid = 2'b01; req_op1 = {32'd0, 32'd77}; req_op2 = {32'd0, 32'd1}; req_ctrl = '0;
        #1;
        chk("midrst grant", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        req_valid = 2'b00; rst = 1'b1;
        #1;
        chk("midrst exec busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst idle busy", 32'(busy), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        m_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("midrst no rsp", 32'(rsp_valid), 32'd0);
        end
        rv = '{2'b10, 32'd0, 32'd0, 3'd0, 32'd1, 32'd1, 3'd0, 0, 2'b00, 1'b1, 32'd2, 1'b0};
        txn(rv, "midrst add");

        for (int i = 0; i < 150; i++) begin
            gm = 2'($urandom_range(1, 3));
            rv.m    = gm;
            rv.a0   = $urandom;
            rv.a1   = $urandom;
            rv.b0   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            rv.b1   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) rv.b0 = rv.a0;
            rv.c0   = 3'($urandom_range(0, 7));
            rv.c1   = 3'($urandom_range(0, 7));
            rv.bp   = $urandom_range(0, 3);
            rv.hold = 2'($urandom_range(0, 3));
            rv.id   = pick(gm, m_last);
            rv.res  = rv.id ? alu_ref(rv.c1, rv.a1, rv.b1) : alu_ref(rv.c0, rv.a0, rv.b0);
            rv.eq   = (rv.res == 32'd0);
            txn(rv, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit combinational `alu` module between two requesters.
- Each requester uses a valid/ready request channel; all requesters share one valid/ready response channel.
- Sequencing is a 3-state FSM: accept, execute, respond. Results are registered and tagged with the requester ID.
- Sits between the execute-stage consumers (main datapath and the address/branch helper) and the shared ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; the `alu` instance uses the same value.
- NUM_REQ, 2, number of requesters; fixed at 2, and the arbitration logic assumes 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept strobe; at most one bit high
- req_op1  in  2*DATA_WIDTH  operand 1; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req_op2  in  2*DATA_WIDTH  operand 2, same slicing
- req_ctrl  in  6  ALU control; slice i = [i*3 +: 3]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester that owns the response
- rsp_result  out  DATA_WIDTH  registered ALU result
- rsp_eq  out  1  registered ALU EQ flag (result == 0)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_eq=0.
  - Operand registers cleared; last_grant=1, so requester 0 wins the first contention.
  - Reset overrides every state. A pending op is discarded and no response is issued.
- Outputs:
  - req_ready is combinational from state/req_valid/last_grant.
  - All other outputs are registered.
- IDLE:
  - If no req_valid, stay in IDLE and req_ready=00.
  - If exactly one req_valid, grant that requester.
  - If both req_valid, grant requester !last_grant (round-robin).
  - On grant: req_ready[g]=1 this cycle; latch op1/op2/ctrl of g and g itself at the edge; last_grant<=g; go to EXEC.
- EXEC:
  - The `alu` is driven from the latched operands only.
  - At the edge: rsp_result<=ALUout, rsp_eq<=EQ, rsp_id<=latched g, rsp_valid<=1; go to RESP.
  - req_ready=00.
- RESP:
  - rsp_valid=1. rsp_result, rsp_eq and rsp_id hold stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0, go to IDLE. rsp_result, rsp_eq and rsp_id keep their last values.
  - req_ready=00 throughout, including on the handshake cycle. There is no accept/respond overlap.
- Latency and throughput:
  - Request accepted at edge T gives rsp_valid=1 in cycle T+2.
  - Best-case throughput is one op per 3 cycles.
- Requester rules:
  - Requesters hold valid and operands stable until their ready bit is seen.
  - The arbiter samples operands only in the grant cycle.
  - Dropping valid before grant is tolerated; no request is queued.
- ALU ctrl encoding, all 8 codes legal:
  - 000 add, 001 sub, 010 and, 011 or
  - 100 slt = {31'b0, op2 < op1} unsigned
  - 101 xor, 110 sll by op2, 111 srl by op2
  - Shift amount is the full op2 value; op2 >= 32 gives 0.
- Arithmetic: add/sub wrap modulo 2^DATA_WIDTH with no carry/overflow output.
- rsp_eq reflects the executed op's result; it is not a separate compare.
- busy=1 in EXEC and RESP, 0 in IDLE.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention. last_grant is not updated or used. Requester 1 can starve, which is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset: assert rst 2 cycles, all req_valid=11 -> during and after reset: rsp_valid=0, rsp_result=0, rsp_eq=0, busy=0, req_ready=00 while rst=1.
- Single request: req0 op1=5, op2=7, ctrl=000 in cycle T -> req_ready=01 in T; rsp_valid=1 in T+2 with rsp_result=12, rsp_eq=0, rsp_id=0.
- Contention: both valid; req0 sub 9-9, req1 or 0xF0|0x0F, held until granted, with rsp_ready=1:
  - First response: id=0, result=0, eq=1.
  - Second response: id=1, result=0xFF, eq=0.
  - Both valid again -> id=0 granted first, confirming alternation.
  - With ALU_ARB_FIXED_PRIO_EN: req0 wins every time.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP with result 0x1234 and req_valid=11 -> rsp_* stable for 5 cycles, req_ready=00, busy=1; next acceptance occurs 1 cycle after the handshake.
- Reset mid-op: rst=1 in EXEC -> next cycle IDLE, rsp_valid never rises for that op; a new req1 add 1+1 then returns result=2, id=1.
- Shifts/slt:
  - sll 1 by 31 -> 0x80000000.
  - srl 0xFFFFFFFF by 32 -> 0 with eq=1.
  - slt op1=3, op2=2 -> 1.
  - slt op1=2, op2=3 -> 0 with eq=1.
